// File: rtl/pyhdl_via_evq_pkg.sv
// Shared types for the VIA root-event queue.
// Optional PYHDL_VIA_EVQ_TIMESTAMP_EN adds a timestamp field to each stored record.
package pyhdl_via_evq_pkg;
  localparam int ID_W       = 32;
  localparam int KIND_W     = 4;
  localparam int TS_W       = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [KIND_W-1:0] {
    EVT_COMP_CREATE = 4'd0,
    EVT_OBJ_CREATE  = 4'd1,
    EVT_PHASE_START = 4'd2,
    EVT_PHASE_END   = 4'd3
  } evt_kind_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [ID_W-1:0]   id;
`ifdef PYHDL_VIA_EVQ_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } evt_rec_t;

  typedef enum logic {EMPTY = 1'b0, PRESENT = 1'b1} outq_state_e;
endpackage

// File: rtl/pyhdl_via_evq_mem.sv
// Event record storage: one synchronous write port, one asynchronous read port.
module pyhdl_via_evq_mem
  import pyhdl_via_evq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  evt_rec_t         wdata,
  input  logic [PTR_W-1:0] rd_ptr,
  output evt_rec_t         rdata
);
  evt_rec_t store [DEPTH];

  always_ff @(posedge clock) begin
    if (we) store[wr_ptr] <= wdata;
  end

  assign rdata = store[rd_ptr];
endmodule

// File: rtl/pyhdl_via_event_queue.sv
// Never-stalling VIA root-event queue drained through a registered valid/ready output.
// Define PYHDL_VIA_EVQ_TIMESTAMP_EN to stamp each event with a free-running counter (out_ts).
module pyhdl_via_event_queue
  import pyhdl_via_evq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic [KIND_W-1:0]     evt_kind,
  input  logic [ID_W-1:0]       evt_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [KIND_W-1:0]     out_kind,
  output logic [ID_W-1:0]       out_id,
`ifdef PYHDL_VIA_EVQ_TIMESTAMP_EN
  output logic [TS_W-1:0]       out_ts,
`endif
  output logic [CNT_W-1:0]      count,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  overflow
);
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  outq_state_e           state_q, state_d;
  evt_rec_t              out_q, out_d, rec_in, mem_rdata;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic                  full, push, pop, drop;

`ifdef PYHDL_VIA_EVQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  assign ts_d   = ts_q + TS_W'(1);
  assign out_ts = out_q.ts;
  assign rec_in = '{kind: evt_kind, id: evt_id, ts: ts_q};
`else
  assign rec_in = '{kind: evt_kind, id: evt_id};
`endif

  // The head entry stays in storage until popped, so count covers the output register.
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = evt_valid && !full && !flush;
  assign drop = evt_valid && full && !flush;
  assign pop  = (state_q == PRESENT) && out_ready;

  // Read port looks one past the head: that is what gets loaded on a pop.
  pyhdl_via_evq_mem #(.DEPTH(DEPTH)) u_mem (
    .clock  (clock),
    .we     (push),
    .wr_ptr (wr_ptr_q),
    .wdata  (rec_in),
    .rd_ptr (rd_ptr_q + PTR_W'(1)),
    .rdata  (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    out_d    = out_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = EMPTY;
      out_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
      end
      case (state_q)
        EMPTY: if (push) begin
          out_d   = rec_in;
          state_d = PRESENT;
        end
        PRESENT: if (pop) begin
          // With a single entry left, the successor can only be this cycle's push.
          if (count_q > CNT_W'(1)) out_d = mem_rdata;
          else if (push)           out_d = rec_in;
          else                     state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
      out_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef PYHDL_VIA_EVQ_TIMESTAMP_EN
  // Free-running; deliberately untouched by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`endif

  assign evt_ready = !full;
  assign out_valid = (state_q == PRESENT);
  assign out_kind  = out_q.kind;
  assign out_id    = out_q.id;
  assign count     = count_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;
endmodule
